// File: rtl/cla_req_arbiter.sv
// Round-robin issue front-end for a pipelined adder with no stall input: credits reserve
// response FIFO space at issue time, and a tag pipeline steers each returning sum home.
module cla_req_arbiter #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int LAT   = 5,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   rsp_valid,
    input  logic [N-1:0]   rsp_ready,
    output logic [N*W-1:0] rsp_sum,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_sum,
    output logic           busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  elig;
    logic [N-1:0]  issue;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic          grant;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [LAT-1:0] tag_vld_q;
    logic [PW-1:0]  tag_id_q [LAT];

    // Scan from ptr upwards; iterating downwards lets the nearest eligible index win.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (elig[idx[PW-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign req_ready = issue;
    assign add_a     = grant ? req_a[grant_idx*W +: W] : '0;
    assign add_b     = grant ? req_b[grant_idx*W +: W] : '0;
    assign busy      = (|tag_vld_q) | (|rsp_valid);

    // The tag pipeline mirrors the adder's own pipeline and never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= grant;
            tag_id_q[0]  <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        logic [W-1:0]  mem_q [DEPTH];
        logic [AW-1:0] wr_q;
        logic [AW-1:0] rd_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] credit_q;

        assign issue[gi]          = grant && (grant_idx == PW'(gi));
        assign elig[gi]           = req_valid[gi] && (credit_q < CW'(DEPTH));
        assign push[gi]           = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == PW'(gi));
        assign rsp_valid[gi]      = (cnt_q != '0);
        assign pop[gi]            = rsp_valid[gi] && rsp_ready[gi];
        assign rsp_sum[gi*W +: W] = mem_q[rd_q];

        // Credit covers in-flight plus buffered results, so a push never finds the FIFO full.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[d] <= '0;
                end
                wr_q     <= '0;
                rd_q     <= '0;
                cnt_q    <= '0;
                credit_q <= '0;
            end else begin
                if (push[gi]) begin
                    mem_q[wr_q] <= add_sum;
                    wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
                end
                if (pop[gi]) begin
                    rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
                end
                case ({push[gi], pop[gi]})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
                case ({issue[gi], pop[gi]})
                    2'b10:   credit_q <= credit_q + 1'b1;
                    2'b01:   credit_q <= credit_q - 1'b1;
                    default: credit_q <= credit_q;
                endcase
            end
        end
    end
endmodule
